// File: rtl/gcd_pkg.sv
// Shared types and constants for the GCD scheduler and the engine it drives.
package gcd_pkg;

   // Scheduler FSM states
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      RESP  = 2'd3
   } state_t;

   // Defaults shared with the GCD engine
   localparam int DEF_WIDTH   = 16;
   localparam int DEF_TIMEOUT = 1024;

   // Width of a requester index; never narrower than one bit
   function automatic int id_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/gcd_rr_arbiter.sv
// Combinational round-robin pick: the search starts just after the last grant.
module gcd_rr_arbiter
   import gcd_pkg::*;
#(
   parameter int N_REQ = 4,
   parameter int ID_W  = id_width(N_REQ)
) (
   input  logic [N_REQ-1:0] req_valid,
   input  logic [ID_W-1:0]  rr_ptr,
   output logic [N_REQ-1:0] grant,
   output logic [ID_W-1:0]  grant_idx,
   output logic             any_valid
);

   // Walk from farthest to nearest so the nearest valid requester after rr_ptr wins
   always_comb begin
      logic [ID_W-1:0] idx;
      idx       = '0;
      grant_idx = '0;
      any_valid = 1'b0;
      for (int off = N_REQ; off >= 1; off--) begin
         idx = ID_W'((int'(rr_ptr) + off) % N_REQ);
         if (req_valid[idx]) begin
            grant_idx = idx;
            any_valid = 1'b1;
         end else begin
            grant_idx = grant_idx;
         end
      end
      if (any_valid) begin
         grant = {{(N_REQ-1){1'b0}}, 1'b1} << grant_idx;
      end else begin
         grant = '0;
      end
   end

endmodule

// File: rtl/gcd_scheduler.sv
// Round-robin scheduler sharing one start/done GCD engine among N_REQ requesters,
// with a zero-operand bypass and a WAIT timeout that reports an error response.
module gcd_scheduler
   import gcd_pkg::*;
#(
   parameter int N_REQ   = 4,
   parameter int WIDTH   = DEF_WIDTH,
   parameter int TIMEOUT = DEF_TIMEOUT
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic [N_REQ-1:0]             req_valid,
   output logic [N_REQ-1:0]             req_ready,
   input  logic [N_REQ*WIDTH-1:0]       req_a,
   input  logic [N_REQ*WIDTH-1:0]       req_b,
   output logic                         rsp_valid,
   input  logic                         rsp_ready,
   output logic [id_width(N_REQ)-1:0]   rsp_id,
   output logic [WIDTH-1:0]             rsp_result,
   output logic                         rsp_err,
   output logic                         eng_start,
   output logic [WIDTH-1:0]             eng_a,
   output logic [WIDTH-1:0]             eng_b,
   input  logic                         eng_done,
   input  logic [WIDTH-1:0]             eng_result
);

   localparam int ID_W  = id_width(N_REQ);
   localparam int TMR_W = $clog2(TIMEOUT) + 1;

   state_t           state;
   logic [ID_W-1:0]  rr_ptr;
   logic [TMR_W-1:0] timer;

   logic [N_REQ-1:0] grant;
   logic [ID_W-1:0]  grant_idx;
   logic             any_valid;
   logic [WIDTH-1:0] sel_a;
   logic [WIDTH-1:0] sel_b;

   gcd_rr_arbiter #(
      .N_REQ (N_REQ),
      .ID_W  (ID_W)
   ) u_arb (
      .req_valid (req_valid),
      .rr_ptr    (rr_ptr),
      .grant     (grant),
      .grant_idx (grant_idx),
      .any_valid (any_valid)
   );

   // Operands of the currently granted requester
   always_comb begin
      sel_a = req_a[int'(grant_idx)*WIDTH +: WIDTH];
      sel_b = req_b[int'(grant_idx)*WIDTH +: WIDTH];
   end

   // Accept is offered only while idle, so the handshake completes in the grant cycle
   always_comb begin
      if ((state == IDLE) && !rst) begin
         req_ready = grant;
      end else begin
         req_ready = '0;
      end
   end

   // Scheduler FSM with registered response and engine-side outputs
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         rr_ptr     <= ID_W'(N_REQ - 1);
         timer      <= '0;
         rsp_valid  <= 1'b0;
         rsp_id     <= '0;
         rsp_result <= '0;
         rsp_err    <= 1'b0;
         eng_start  <= 1'b0;
         eng_a      <= '0;
         eng_b      <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (any_valid) begin
                  rr_ptr <= grant_idx;
                  rsp_id <= grant_idx;
                  eng_a  <= sel_a;
                  eng_b  <= sel_b;
                  // gcd(x,0)=x and gcd(0,0)=0, so a zero operand never needs the engine
                  if ((sel_a == {WIDTH{1'b0}}) || (sel_b == {WIDTH{1'b0}})) begin
                     rsp_result <= sel_a | sel_b;
                     rsp_err    <= 1'b0;
                     rsp_valid  <= 1'b1;
                     state      <= RESP;
                  end else begin
                     eng_start <= 1'b1;
                     state     <= ISSUE;
                  end
               end else begin
                  state <= IDLE;
               end
            end
            ISSUE: begin
               eng_start <= 1'b0;
               timer     <= '0;
               state     <= WAIT;
            end
            WAIT: begin
               // Completion takes precedence over a coincident timeout
               if (eng_done) begin
                  rsp_result <= eng_result;
                  rsp_err    <= 1'b0;
                  rsp_valid  <= 1'b1;
                  state      <= RESP;
               end else if (timer == TMR_W'(TIMEOUT - 1)) begin
                  rsp_result <= '0;
                  rsp_err    <= 1'b1;
                  rsp_valid  <= 1'b1;
                  state      <= RESP;
               end else begin
                  timer <= timer + TMR_W'(1);
               end
            end
            RESP: begin
               if (rsp_ready) begin
                  rsp_valid <= 1'b0;
                  state     <= IDLE;
               end else begin
                  state <= RESP;
               end
            end
            default: begin
               state     <= IDLE;
               rsp_valid <= 1'b0;
               eng_start <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_gcd_scheduler.sv
// Scoreboard bench for gcd_scheduler: stimulus pushes hand-computed responses,
// a monitor pops and compares on each response handshake; a behavioural engine
// answers eng_start after a programmable latency or hangs on request.
module tb_gcd_scheduler;

   localparam int N   = 4;
   localparam int W   = 16;
   localparam int TO  = 16;
   localparam int IDW = 2;

   logic           clk = 1'b0;
   logic           rst;
   logic [N-1:0]   req_valid;
   logic [N-1:0]   req_ready;
   logic [N*W-1:0] req_a;
   logic [N*W-1:0] req_b;
   logic           rsp_valid;
   logic           rsp_ready;
   logic [IDW-1:0] rsp_id;
   logic [W-1:0]   rsp_result;
   logic           rsp_err;
   logic           eng_start;
   logic [W-1:0]   eng_a;
   logic [W-1:0]   eng_b;
   logic           eng_done;
   logic [W-1:0]   eng_result;

   gcd_scheduler #(.N_REQ(N), .WIDTH(W), .TIMEOUT(TO)) dut (
      .clk        (clk),
      .rst        (rst),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_a      (req_a),
      .req_b      (req_b),
      .rsp_valid  (rsp_valid),
      .rsp_ready  (rsp_ready),
      .rsp_id     (rsp_id),
      .rsp_result (rsp_result),
      .rsp_err    (rsp_err),
      .eng_start  (eng_start),
      .eng_a      (eng_a),
      .eng_b      (eng_b),
      .eng_done   (eng_done),
      .eng_result (eng_result)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic [IDW-1:0] id;
      logic [W-1:0]   res;
      logic           err;
      int             lat;
   } exp_t;

   typedef struct {
      logic [W-1:0] a;
      logic [W-1:0] b;
   } ops_t;

   exp_t           exp_q[$];
   ops_t           op_q[$];
   int             hs_q[$];
   int             hs_count = 0;
   logic [IDW-1:0] hs_last = '0;
   int             tests = 0;
   int             fails = 0;
   int             eng_lat = 3;
   bit             eng_hang = 1'b0;
   int             eng_starts = 0;
   int             starts_before;

   task automatic check(input string name, input longint act, input longint req);
      tests++;
      if (act != req) begin
         fails++;
         $display("FAIL %s: got %0d, required %0d (t=%0t)", name, act, req, $time);
      end
   endtask

   // Subtractive GCD used only by the engine model
   function automatic logic [W-1:0] gcd_ref(input logic [W-1:0] a, input logic [W-1:0] b);
      logic [W-1:0] x, y;
      x = a;
      y = b;
      if (x == 0) return y;
      if (y == 0) return x;
      while (x != y) begin
         if (x > y) x = x - y;
         else       y = y - x;
      end
      return x;
   endfunction

   // Request handshake monitor
   initial begin
      forever begin
         @(negedge clk);
         if (!rst && ((req_valid & req_ready) != '0)) begin
            hs_q.push_back(cyc);
            hs_count++;
            for (int i = 0; i < N; i++) begin
               if (req_ready[i]) hs_last = IDW'(i);
            end
         end
      end
   end

   // Response monitor: latency on rising rsp_valid, contents on accept
   initial begin
      bit   prev;
      int   h;
      exp_t e;
      prev = 1'b0;
      forever begin
         @(negedge clk);
         if (rsp_valid && !prev) begin
            if (hs_q.size() == 0) begin
               check("rsp_without_handshake", 1, 0);
            end else begin
               h = hs_q.pop_front();
               if (exp_q.size() > 0) check("rsp_latency", cyc - h, exp_q[0].lat);
            end
         end
         if (rsp_valid && rsp_ready) begin
            if (exp_q.size() == 0) begin
               check("unexpected_rsp", 1, 0);
            end else begin
               e = exp_q.pop_front();
               check("rsp_id", rsp_id, e.id);
               check("rsp_result", rsp_result, e.res);
               check("rsp_err", rsp_err, e.err);
            end
         end
         prev = rsp_valid;
      end
   end

   // Behavioural engine: answers eng_start with gcd after eng_lat cycles unless hanging
   initial begin
      logic [W-1:0] a0, b0;
      ops_t o;
      eng_done   = 1'b0;
      eng_result = '0;
      forever begin
         @(posedge clk);
         #1;
         if (eng_start && !rst) begin
            a0 = eng_a;
            b0 = eng_b;
            eng_starts++;
            if (op_q.size() == 0) begin
               check("unexpected_eng_start", 1, 0);
            end else begin
               o = op_q.pop_front();
               check("eng_a", a0, o.a);
               check("eng_b", b0, o.b);
            end
            @(posedge clk);
            #1;
            check("eng_start_one_cycle", eng_start, 0);
            if (!eng_hang) begin
               repeat (eng_lat - 1) @(posedge clk);
               #1;
               check("eng_a_stable", eng_a, a0);
               eng_result = gcd_ref(a0, b0);
               eng_done   = 1'b1;
               @(posedge clk);
               #1;
               eng_done   = 1'b0;
               eng_result = '0;
            end
         end
      end
   end

   task automatic set_req(input int i, input logic [W-1:0] a, input logic [W-1:0] b);
      req_a[i*W +: W] = a;
      req_b[i*W +: W] = b;
      req_valid[i]    = 1'b1;
   endtask

   task automatic push_exp(input int id, input int res, input bit err, input int lat);
      exp_t e;
      e.id  = IDW'(id);
      e.res = W'(res);
      e.err = err;
      e.lat = lat;
      exp_q.push_back(e);
   endtask

   task automatic push_ops(input int a, input int b);
      ops_t o;
      o.a = W'(a);
      o.b = W'(b);
      op_q.push_back(o);
   endtask

   // Wait for n request handshakes; optionally drop the winner's valid afterwards
   task automatic wait_hs(input int n, input bit drop);
      int base, got;
      base = hs_count;
      got  = 0;
      for (int c = 0; c < 400 && got < n; c++) begin
         @(posedge clk);
         #1;
         if (hs_count > base + got) begin
            if (drop) req_valid[hs_last] = 1'b0;
            got++;
         end
      end
      if (got < n) check("handshake_timeout", got, n);
   endtask

   task automatic wait_idle(input int budget);
      bit done;
      done = 1'b0;
      for (int c = 0; c < budget && !done; c++) begin
         @(posedge clk);
         #1;
         if (exp_q.size() == 0 && !rsp_valid) done = 1'b1;
      end
      if (!done) check("drain_timeout", exp_q.size(), 0);
   endtask

   task automatic check_cleared(input string tag);
      check({tag, "_rsp_valid"},  rsp_valid,  0);
      check({tag, "_req_ready"},  req_ready,  0);
      check({tag, "_eng_start"},  eng_start,  0);
      check({tag, "_eng_a"},      eng_a,      0);
      check({tag, "_eng_b"},      eng_b,      0);
      check({tag, "_rsp_id"},     rsp_id,     0);
      check({tag, "_rsp_result"}, rsp_result, 0);
      check({tag, "_rsp_err"},    rsp_err,    0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, tests=%0d", tests);
      $fatal(1, "watchdog");
   end

   initial begin
      rst       = 1'b1;
      req_valid = '0;
      req_a     = '0;
      req_b     = '0;
      rsp_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      check_cleared("reset");
      rst = 1'b0;

      // 1: single engine job, latency 2 + 10
      eng_lat = 10;
      push_ops(48, 18);
      push_exp(1, 6, 1'b0, 12);
      set_req(1, 16'd48, 16'd18);
      wait_hs(1, 1'b1);
      wait_idle(100);
      check("t1_eng_starts", eng_starts, 1);

      // 2: all four valid from reset, two full rounds in order 0..3
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst     = 1'b0;
      eng_lat = 3;
      for (int r = 0; r < 2; r++) begin
         push_ops(12, 8);  push_exp(0, 4, 1'b0, 5);
         push_ops(9, 6);   push_exp(1, 3, 1'b0, 5);
         push_ops(35, 14); push_exp(2, 7, 1'b0, 5);
         push_ops(27, 18); push_exp(3, 9, 1'b0, 5);
      end
      set_req(0, 16'd12, 16'd8);
      set_req(1, 16'd9,  16'd6);
      set_req(2, 16'd35, 16'd14);
      set_req(3, 16'd27, 16'd18);
      wait_hs(8, 1'b0);
      req_valid = '0;
      wait_idle(300);

      // 3: zero-operand bypass, one cycle latency, engine untouched
      starts_before = eng_starts;
      push_exp(2, 7, 1'b0, 1);
      set_req(2, 16'd0, 16'd7);
      wait_hs(1, 1'b1);
      push_exp(2, 0, 1'b0, 1);
      set_req(2, 16'd0, 16'd0);
      wait_hs(1, 1'b1);
      wait_idle(50);
      check("t3_no_eng_start", eng_starts, starts_before);

      // 4: hung engine times out after 16 WAIT cycles, then a normal job
      eng_hang = 1'b1;
      push_ops(10, 4);
      push_exp(0, 0, 1'b1, 18);
      set_req(0, 16'd10, 16'd4);
      wait_hs(1, 1'b1);
      wait_idle(100);
      eng_hang = 1'b0;
      eng_lat  = 2;
      push_ops(10, 4);
      push_exp(0, 2, 1'b0, 4);
      set_req(0, 16'd10, 16'd4);
      wait_hs(1, 1'b1);
      wait_idle(100);

      // 5: response back-pressure with 1 and 3 pending; after granting 2, 3 wins
      rsp_ready = 1'b0;
      push_exp(2, 5, 1'b0, 1);
      push_exp(3, 4, 1'b0, 1);
      push_exp(1, 9, 1'b0, 1);
      set_req(2, 16'd0, 16'd5);
      wait_hs(1, 1'b1);
      set_req(1, 16'd0, 16'd9);
      set_req(3, 16'd4, 16'd0);
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         check("t5_hold_valid",  rsp_valid,  1);
         check("t5_hold_id",     rsp_id,     2);
         check("t5_hold_result", rsp_result, 5);
         check("t5_hold_err",    rsp_err,    0);
         check("t5_req_ready",   req_ready,  0);
      end
      @(posedge clk);
      #1;
      rsp_ready = 1'b1;
      wait_hs(2, 1'b1);
      wait_idle(50);

      // 6: asynchronous reset in the middle of WAIT abandons the job
      eng_hang = 1'b1;
      push_ops(15, 5);
      set_req(1, 16'd15, 16'd5);
      wait_hs(1, 1'b1);
      repeat (5) @(posedge clk);
      #3;
      rst = 1'b1;
      #1;
      check_cleared("midwait_reset");
      hs_q.delete();
      @(posedge clk);
      #1;
      rst      = 1'b0;
      eng_hang = 1'b0;
      push_exp(0, 6, 1'b0, 1);
      push_exp(3, 3, 1'b0, 1);
      set_req(0, 16'd6, 16'd0);
      set_req(3, 16'd0, 16'd3);
      wait_hs(2, 1'b1);
      wait_idle(50);

      check("scoreboard_drained", exp_q.size(), 0);
      check("engine_ops_drained", op_q.size(), 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/gcd_scheduler.md
Name: gcd_scheduler

Overview:
- Round-robin scheduler that shares one subtract-based GCD engine (controller plus datapath) among N_REQ requesters.
- Arbitrates requests and captures operands.
- Sequences the engine with a start/done handshake.
- Bypasses the engine for zero operands.
- Guards against engine hang with a timeout.
- Returns an ID-tagged result on a valid/ready response port.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- WIDTH, 16, operand and result width.
- TIMEOUT, 1024, maximum WAIT cycles before aborting with error.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- req_valid  input  N_REQ  per-requester request valid.
- req_ready  output  N_REQ  per-requester accept (one-hot or zero).
- req_a  input  N_REQ*WIDTH  operand A; requester i occupies bits [i*WIDTH +: WIDTH].
- req_b  input  N_REQ*WIDTH  operand B, same packing as req_a.
- rsp_valid  output  1  response valid.
- rsp_ready  input  1  response accept.
- rsp_id  output  $clog2(N_REQ)  requester index of the response.
- rsp_result  output  WIDTH  GCD result.
- rsp_err  output  1  engine timed out.
- eng_start  output  1  one-cycle engine start pulse.
- eng_a  output  WIDTH  captured operand A, stable from ISSUE through WAIT.
- eng_b  output  WIDTH  captured operand B, stable from ISSUE through WAIT.
- eng_done  input  1  engine completion (level or pulse).
- eng_result  input  WIDTH  engine result, valid while eng_done=1.

Behaviour:
- Reset (async, immediate):
  - state=IDLE, rr_ptr=N_REQ-1, so requester 0 has priority first.
  - req_ready=0, rsp_valid=0, rsp_id=0, rsp_result=0, rsp_err=0, eng_start=0, eng_a=0, eng_b=0, timer=0.
  - Reset mid-operation abandons the in-flight job with no response; the engine shares rst.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - Grant g = first i with req_valid[i]=1, searching rr_ptr+1, rr_ptr+2, ... modulo N_REQ.
  - req_ready[g]=1 combinationally, same cycle; handshake completes that cycle.
  - On handshake: capture a, b, id=g; set rr_ptr<=g.
  - If a==0 or b==0: result=a|b (so gcd(0,0)=0), err=0, go to RESP and skip the engine.
  - Otherwise go to ISSUE.
  - No req_valid: stay in IDLE with req_ready=0.
- ISSUE: eng_start=1 for exactly one cycle; timer<=0; go to WAIT.
- WAIT:
  - eng_done=1: result<=eng_result, err<=0, go to RESP.
  - Otherwise timer increments. When timer==TIMEOUT-1 without eng_done: result<=0, err<=1, go to RESP.
  - eng_done and timeout in the same cycle: eng_done wins.
- RESP:
  - rsp_valid=1; rsp_id, rsp_result and rsp_err held stable until rsp_ready=1.
  - When rsp_ready=1: rsp_valid drops next cycle and state returns to IDLE.
  - req_ready=0 throughout.
- eng_done outside WAIT is ignored.
- req_ready is 0 in every state except IDLE, so at most one job is in flight.
- Latency, handshake at cycle k:
  - Bypass: rsp_valid at k+1.
  - Engine: eng_start at k+1; if eng_done arrives at k+1+L (L>=1), rsp_valid at k+2+L.
- A requester that drops req_valid before being granted loses nothing; there is no queueing.
- Fairness: a continuously requesting requester waits at most N_REQ-1 other jobs.

Decomposition:
- Package gcd_pkg:
  - state enum {IDLE, ISSUE, WAIT, RESP}.
  - ID_W = $clog2(N_REQ) helper.
  - Default WIDTH and TIMEOUT constants, shared with the GCD engine.
- One sub-module, gcd_rr_arbiter:
  - Combinational round-robin pick from req_valid and rr_ptr.
  - Outputs a one-hot grant, the grant index and an any-valid flag.
- gcd_scheduler holds the FSM, operand/result registers, timer and pointer.

Test Plan:
1. Requester 1 only, (48, 18); engine model returns 6 after 10 cycles -> one eng_start pulse with eng_a=48, eng_b=18; rsp_id=1, rsp_result=6, rsp_err=0; rsp_valid exactly 12 cycles after handshake.
2. All four requesters valid after reset, operands (12,8), (9,6), (35,14), (27,18) -> grants in order 0,1,2,3; results 4, 3, 7, 9. Keep all valid for a second round -> order again 0,1,2,3.
3. Requester 2 sends (0, 7) then (0, 0) -> results 7 then 0, rsp_err=0, eng_start never asserted, rsp_valid one cycle after each handshake.
4. Engine never raises eng_done, TIMEOUT=16 -> rsp_err=1, rsp_result=0 after 16 WAIT cycles; the next request is served normally.
5. rsp_ready held low for 20 cycles with other requests pending -> rsp fields stable, req_ready all 0 until accept; next grant follows rr_ptr.
6. rst asserted mid-WAIT -> outputs cleared immediately without a clock edge; no stale response appears; after release requester 0 wins a simultaneous 0/3 request.
